// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state enum and sizing constants for the 8-way round-robin mux arbiter
package mux_arb_pkg;
  typedef enum logic {IDLE, OWN} arb_state_e;
  localparam int N_AGENTS = 8;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] RST_LAST = 3'd7;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin picker, first set req bit scanning last+1 .. last+8 mod 8
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_AGENTS-1:0] req,
  input  logic [SEL_W-1:0]    last,
  output logic                any,
  output logic [SEL_W-1:0]    idx
);
  assign any = |req;
  always_comb begin
    idx = '0;
    for (int k = N_AGENTS; k >= 1; k--)
      idx = req[last + SEL_W'(k)] ? last + SEL_W'(k) : idx;
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of an 8:1 bit mux; MUX_ARB_TIMEOUT_EN enables forced release after MAX_HOLD cycles
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_AGENTS-1:0] req,
  input  logic [N_AGENTS-1:0] D,
  output logic [N_AGENTS-1:0] gnt,
  output logic [SEL_W-1:0]    S,
  output logic                out,
  output logic                out_valid,
  output logic                timeout
);
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("MAX_HOLD must be >= 1");
  end
  arb_state_e       r_state, w_next;
  logic [SEL_W-1:0] r_sel, r_last, w_idx;
  logic             r_out, r_valid, r_to, w_any, w_drop, w_to;
  rr_pick8 u_pick (.req(req), .last(r_last), .any(w_any), .idx(w_idx));
  assign w_drop = (r_state == OWN) && !req[r_sel];
`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] r_hold;
  always_ff @(posedge clk)
    r_hold <= (rst || r_state == IDLE) ? '0 : r_hold + CW'(1);
  // voluntary drop wins over expiry on the same edge, so timeout needs req[S] still high
  assign w_to = (r_state == OWN) && req[r_sel] && (r_hold == CW'(MAX_HOLD - 1));
`else
  assign w_to = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_any ? OWN : IDLE) : ((w_drop || w_to) ? IDLE : OWN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_last  <= RST_LAST;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_to    <= w_to;
      r_valid <= (r_state == OWN) && (w_next == OWN);
      if (r_state == OWN) r_out <= D[r_sel];
      if (r_state == IDLE && w_any) r_sel <= w_idx;
      if (r_state == OWN && w_next == IDLE) r_last <= r_sel;
    end
  end
  assign gnt       = (r_state == OWN) ? {{(N_AGENTS-1){1'b0}}, 1'b1} << r_sel : '0;
  assign S         = r_sel;
  assign out       = r_out;
  assign out_valid = r_valid;
  assign timeout   = r_to;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed table plus multi-cycle sequences for the round-robin mux arbiter
module tb_mux8_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] D = '0;
  logic [7:0] gnt;
  logic [2:0] S;
  logic       out, out_valid, timeout;
  int n_chk = 0;
  int n_fail = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .D(D), .gnt(gnt), .S(S),
    .out(out), .out_valid(out_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic [7:0] d;
    logic [7:0] g;
    logic [2:0] s;
    logic       o;
    logic       v;
  } vec_t;
  vec_t tbl[26];

  task automatic step(input logic r, input logic [7:0] q, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    req = q;
    D = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h01, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 8'h01, 8'h00, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h09, 8'h00, 8'h08, 3'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h09, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h01, 8'h08, 8'h00, 3'd3, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'hFF, 8'hFB, 8'h04, 3'd2, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 8'hF6, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 8'h04, 8'hFB, 8'h04, 3'd2, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 8'h04, 8'h00, 3'd2, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 8'h10, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 8'h10, 8'h00, 8'h10, 3'd4, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 8'h10, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 8'h10, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 8'h81, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    tbl[23] = '{1'b0, 8'h00, 8'h01, 8'h00, 3'd0, 1'b1, 1'b0};
    tbl[24] = '{1'b0, 8'h40, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    tbl[25] = '{1'b0, 8'h00, 8'h40, 8'h00, 3'd6, 1'b1, 1'b0};
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r, tbl[i].q, tbl[i].d);
      chk($sformatf("row%0d gnt", i), gnt, tbl[i].g);
      chk($sformatf("row%0d S", i), {5'd0, S}, {5'd0, tbl[i].s});
      chk($sformatf("row%0d out", i), {7'd0, out}, {7'd0, tbl[i].o});
      chk($sformatf("row%0d out_valid", i), {7'd0, out_valid}, {7'd0, tbl[i].v});
      chk($sformatf("row%0d timeout", i), {7'd0, timeout}, 8'd0);
    end
    // all agents requesting, each owner drops after two OWN cycles
    step(1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << (k % 8);
      step(1'b0, 8'hFF, 8'hAA);
      chk($sformatf("rr%0d grant", k), gnt, oh);
      chk($sformatf("rr%0d S", k), {5'd0, S}, 8'(k % 8));
      step(1'b0, 8'hFF, 8'hAA);
      chk($sformatf("rr%0d hold", k), gnt, oh);
      chk($sformatf("rr%0d valid", k), {7'd0, out_valid}, 8'd1);
      chk($sformatf("rr%0d out", k), {7'd0, out}, {7'd0, k[0]});
      step(1'b0, 8'hFF & ~oh, 8'hAA);
      chk($sformatf("rr%0d dead", k), gnt, 8'h00);
    end
`ifdef MUX_ARB_TIMEOUT_EN
    step(1'b1, 8'h00, 8'h00);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 8'h20, 8'h20);
      chk($sformatf("to_own%0d", c), gnt, 8'h20);
      chk($sformatf("to_quiet%0d", c), {7'd0, timeout}, 8'd0);
    end
    step(1'b0, 8'h20, 8'h20);
    chk("to_release", gnt, 8'h00);
    chk("to_pulse", {7'd0, timeout}, 8'd1);
    step(1'b0, 8'h20, 8'h20);
    chk("to_regrant5", gnt, 8'h20);
    chk("to_pulse_end", {7'd0, timeout}, 8'd0);
    for (int c = 0; c < 3; c++) step(1'b0, 8'h21, 8'h20);
    chk("to_own_again", gnt, 8'h20);
    step(1'b0, 8'h21, 8'h20);
    chk("to_release2", gnt, 8'h00);
    chk("to_pulse2", {7'd0, timeout}, 8'd1);
    step(1'b0, 8'h21, 8'h20);
    chk("to_regrant0", gnt, 8'h01);
`else
    step(1'b1, 8'h00, 8'h00);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 8'h20, 8'h20);
      chk($sformatf("hold%0d gnt", c), gnt, 8'h20);
      chk($sformatf("hold%0d timeout", c), {7'd0, timeout}, 8'd0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
